// File: rtl/one_to_four.sv
// one_to_four: registered 1-to-4 demultiplexer.
// Manual mode steers each valid word to channel {s1,s0}. TDM mode uses a slot
// counter aligned by a start-of-frame marker to rebuild four parallel channels
// from a serial word stream. All outputs are registered and the latency is one cycle.
module one_to_four #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic [1:0]       slot,
  output logic             frame_done,
  output logic             sync_err
);

  // HUNT waits for a start-of-frame marker. RUN distributes words by slot.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       v_q, v_d;
  logic             fd_q, fd_d;
  logic             se_q, se_d;
  logic [1:0]       man_sel_s;

  // Return the one-hot valid strobe for a channel index.
  function automatic logic [3:0] chan_strobe(input logic [1:0] ch);
    logic [3:0] res;
    case (ch)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  assign man_sel_s = {s1, s0};

  // Next-state decode. Outputs hold by default and pulses default low.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    for (int k = 0; k < 4; k++) begin
      y_d[k] = y_q[k];
    end
    v_d  = 4'b0000;
    fd_d = 1'b0;
    se_d = 1'b0;

    if (!mode) begin
      // Manual mode drops any TDM alignment on every edge.
      state_d = HUNT;
      slot_d  = 2'd0;
      if (din_valid) begin
        y_d[man_sel_s] = din;
        v_d            = chan_strobe(man_sel_s);
      end else begin
        v_d = 4'b0000;
      end
    end else begin
      case (state_q)
        HUNT: begin
          // Words are dropped until a frame marker arrives.
          if (din_valid && sof) begin
            y_d[0]  = din;
            v_d     = 4'b0001;
            slot_d  = 2'd1;
            state_d = RUN;
          end else begin
            state_d = HUNT;
          end
        end
        RUN: begin
          if (din_valid) begin
            if (sof) begin
              // A marker always realigns to slot 0. A marker that arrives
              // mid-frame abandons the partial frame and flags the slip.
              y_d[0] = din;
              v_d    = 4'b0001;
              slot_d = 2'd1;
              se_d   = (slot_q != 2'd0);
            end else begin
              y_d[slot_q] = din;
              v_d         = chan_strobe(slot_q);
              slot_d      = slot_q + 2'd1;
              fd_d        = (slot_q == 2'd3);
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= {WIDTH{1'b0}};
      end
      v_q  <= 4'b0000;
      fd_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= y_d[k];
      end
      v_q  <= v_d;
      fd_q <= fd_d;
      se_q <= se_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign v0         = v_q[0];
  assign v1         = v_q[1];
  assign v2         = v_q[2];
  assign v3         = v_q[3];
  assign slot       = slot_q;
  assign frame_done = fd_q;
  assign sync_err   = se_q;

endmodule

// File: doc/one_to_four.md
# one_to_four

Receive-end counterpart of the 4:1 selector: a registered 1-to-4 demultiplexer that steers a WIDTH-bit input word onto one of four held output channels. It has two modes. In manual mode, select lines s1:s0 choose the channel directly. In TDM mode, an internal slot counter, aligned by a start-of-frame marker, distributes consecutive words to channels 0..3. It sits downstream of a four_to_one-style serialiser and rebuilds the four parallel channels.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (must be >= 1)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- mode  input  1  0 = manual select, 1 = TDM auto-slot
- s0  input  1  manual select LSB
- s1  input  1  manual select MSB; channel = {s1,s0}
- din  input  WIDTH  input data word
- din_valid  input  1  din is valid this cycle
- sof  input  1  start of frame; qualified by din_valid; TDM mode only
- y0, y1, y2, y3  output  WIDTH  registered channel outputs; each holds its last captured word
- v0, v1, v2, v3  output  1  one-cycle pulse; high in the cycle that the matching yk shows a newly captured word
- slot  output  2  TDM slot that the next valid word will fill
- frame_done  output  1  one-cycle pulse after a word is captured into slot 3 in TDM mode
- sync_err  output  1  one-cycle pulse after sof arrives while slot != 0

## Operation
- Reset (rst=1 at an edge) clears all state and overrides every other input:
  - y0..y3 = 0, v0..v3 = 0
  - slot = 0, frame_done = 0, sync_err = 0
  - FSM = HUNT
- A cycle with din_valid=0 changes nothing. Outputs yk hold; all pulses are 0 in the next cycle.
- Manual mode (mode=1'b0):
  - With din_valid=1: y[{s1,s0}] <= din and v[{s1,s0}] <= 1. The other channels and their v bits are unaffected (v=0).
  - sof is ignored.
  - FSM is forced to HUNT and slot to 0 on every edge while mode=0.
- TDM mode (mode=1'b1), FSM states HUNT and RUN:
  - HUNT, din_valid=1 and sof=0: word dropped. No v pulse, no error.
  - HUNT, din_valid=1 and sof=1: y0 <= din, v0 pulse, slot <= 1, go to RUN.
  - RUN, din_valid=1 and sof=0: y[slot] <= din, v[slot] pulse, slot <= slot+1 (mod 4).
    - If slot was 3: frame_done pulse and slot wraps to 0. FSM stays in RUN.
  - RUN, din_valid=1 and sof=1 with slot==0: normal capture to y0, slot <= 1.
  - RUN, din_valid=1 and sof=1 with slot!=0: sync_err pulse, y0 <= din, v0 pulse, slot <= 1 (resync). The partial frame is abandoned; frame_done is not pulsed.
- At most one vk is high in any cycle.
- Switching mode from 1 to 0 mid-frame discards TDM alignment. The first manual write happens on that same edge.
- Switching mode from 0 to 1 always starts in HUNT.

## Timing
- Latency is 1 cycle. A word sampled with din_valid=1 at edge N appears on yk after edge N, with vk high for exactly that cycle.
- frame_done and sync_err are coincident with the v pulse of the word that caused them.
- Back-to-back valid words every cycle are supported, giving full throughput of one word per clock.
- slot is registered and reflects state after the last edge.
- There is no backpressure: din_valid is never stalled.

## Test plan
- Reset: drive garbage inputs, then hold rst for 2 cycles -> y0..y3 = 8'h00, all v/frame_done/sync_err = 0, slot = 0.
- Manual steer: mode=0, write {s1,s0} = 00,01,10,11 with din = A5,3C,F0,0F on consecutive cycles.
  - y0=A5, y1=3C, y2=F0, y3=0F.
  - v0..v3 each pulse once, in order, one cycle after the corresponding sample.
- TDM frame with bubbles: mode=1, send sof+11, idle, 22, 33, idle, 44.
  - y0..y3 = 11,22,33,44.
  - slot sequence 1,1,2,3,3,0.
  - frame_done pulses once, with v3.
- Hunt drop: mode=1 from reset, send 55 and 66 without sof, then sof+77.
  - No v pulse for 55 or 66.
  - y0=77, slot=1, sync_err stays 0.
- Sync error: in RUN after 2 words (slot=2), send sof+99.
  - sync_err and v0 pulse, y0=99, slot=1.
  - y2 is unchanged.
- Reset mid-frame: rst after 2 TDM words.
  - All outputs clear.
  - The next non-sof valid word is dropped (HUNT).
